// File: rtl/hex_scroll_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_scroll_ctrl_pkg                                        |
// | Description : Shared types and constants for the HEX rotating display    |
// |               control slice: debounce state encoding, board constants    |
// |               and the modular position step helper.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package hex_scroll_ctrl_pkg;

    // Board clock and key polarity.
    localparam int unsigned c_CLK_HZ      = 50_000_000;
    localparam logic        c_KEY_PRESSED = 1'b0;

    // Debounce FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        REL        = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } deb_state_t;

    // Wrap-around step over 0..n-1. reverse=0 counts up, reverse=1 counts down.
    function automatic int unsigned pos_step(input int unsigned p,
                                             input logic        reverse,
                                             input int unsigned n);
        if (!reverse) begin
            return (p == n - 32'd1) ? 32'd0 : p + 32'd1;
        end
        return (p == 32'd0) ? n - 32'd1 : p - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_debounce                                               |
// | Description : 2-flop synchronizer plus four-state debounce FSM for an    |
// |               active-low push-button. Emits a one-cycle press pulse once |
// |               the key has been stably down for DEBOUNCE_CYCLES samples;  |
// |               holding the key never repeats the pulse.                   |
// | Ports       : clk, rst (sync, active-high), key_n (async, active-low),   |
// |               press (one-cycle pulse)                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module key_debounce
    import hex_scroll_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned           c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    deb_state_t         r_state;
    deb_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_key_down;

    // Synchronizer flops idle at the released level so reset never looks
    // like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= REL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_key_down = (r_sync2 == c_KEY_PRESSED);

    // r_cnt holds the number of stable samples already seen in a *_WAIT
    // state; the sample that makes it DEBOUNCE_CYCLES fires the transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        press       = 1'b0;
        case (r_state)
            REL: begin
                if (w_key_down) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_key_down) begin
                    w_state_nxt = REL;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = HELD;
                    press       = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_key_down) begin
                    w_state_nxt = REL_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            REL_WAIT: begin
                if (w_key_down) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = REL;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = REL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_scroll_ctrl                                            |
// | Description : Rotation position generator for the four-digit HEX         |
// |               rotating display. Free-runs at TICK_HZ when run_sw=1,      |
// |               single-steps on a debounced key press when run_sw=0.       |
// | Ports       : clk, rst (sync, active-high)                               |
// |               run_sw, dir_sw, step_key_n - asynchronous board inputs     |
// |               pos     - current rotation position                        |
// |               adv     - one-cycle pulse in the first cycle of a new pos  |
// |               running - synchronized run_sw                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hex_scroll_ctrl
    import hex_scroll_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = c_CLK_HZ,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned NUM_POS         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run_sw,
    input  logic                       dir_sw,
    input  logic                       step_key_n,
    output logic [$clog2(NUM_POS)-1:0] pos,
    output logic                       adv,
    output logic                       running
);

    localparam int unsigned            c_div      = CLK_HZ / TICK_HZ;
    localparam int unsigned            c_pre_w    = $clog2(c_div);
    localparam int unsigned            c_pos_w    = $clog2(NUM_POS);
    localparam logic [c_pre_w-1:0]     c_pre_last = c_pre_w'(c_div - 1);

    logic               r_run_s1;
    logic               r_run_s2;
    logic               r_dir_s1;
    logic               r_dir_s2;
    logic [c_pre_w-1:0] r_pre;
    logic [c_pos_w-1:0] r_pos;
    logic [c_pos_w-1:0] w_pos_nxt;
    logic               r_adv;
    logic               w_tick;
    logic               w_press;
    logic               w_advance;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .key_n (step_key_n),
        .press (w_press)
    );

    assign w_tick = r_run_s2 && (r_pre == c_pre_last);

    // Mode is taken from the synchronized run level of the same cycle, so a
    // press while running is simply dropped rather than queued.
    assign w_advance = (r_run_s2 && w_tick) || (!r_run_s2 && w_press);

    assign w_pos_nxt = c_pos_w'(pos_step(32'(r_pos), r_dir_s2, NUM_POS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_s1 <= 1'b0;
            r_run_s2 <= 1'b0;
            r_dir_s1 <= 1'b0;
            r_dir_s2 <= 1'b0;
            r_pre    <= '0;
            r_pos    <= '0;
            r_adv    <= 1'b0;
        end else begin
            r_run_s1 <= run_sw;
            r_run_s2 <= r_run_s1;
            r_dir_s1 <= dir_sw;
            r_dir_s2 <= r_dir_s1;

            // Held at zero while stopped so the first tick after enabling
            // arrives a full period later.
            if (!r_run_s2 || (r_pre == c_pre_last)) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            r_adv <= w_advance;
            if (w_advance) begin
                r_pos <= w_pos_nxt;
            end
        end
    end

    assign pos     = r_pos;
    assign adv     = r_adv;
    assign running = r_run_s2;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hex_scroll_ctrl                                         |
// | Description : Directed self-checking bench for hex_scroll_ctrl with      |
// |               CLK_HZ=8, TICK_HZ=1 (tick every 8 cycles),                 |
// |               DEBOUNCE_CYCLES=4, NUM_POS=4.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hex_scroll_ctrl;

    logic       clk;
    logic       rst;
    logic       run_sw;
    logic       dir_sw;
    logic       step_key_n;
    logic [1:0] pos;
    logic       adv;
    logic       running;

    int total;
    int bad;
    int exp_pos;

    hex_scroll_ctrl #(
        .CLK_HZ          (8),
        .TICK_HZ         (1),
        .NUM_POS         (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_sw     (run_sw),
        .dir_sw     (dir_sw),
        .step_key_n (step_key_n),
        .pos        (pos),
        .adv        (adv),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges; outputs are observed and inputs changed 1 ns after.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        total++;
        assert (obs === 32'(expv)) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int step4(input int p, input int d);
        if (d == 0) return (p == 3) ? 0 : p + 1;
        return (p == 0) ? 3 : p - 1;
    endfunction

    // Run n edges; an advance is expected on edge 'first' and every 8 after.
    task automatic run_auto(input int n, input int first, input int d);
        for (int c = 1; c <= n; c++) begin
            int ea;
            cyc(1);
            ea = (c >= first && ((c - first) % 8) == 0) ? 1 : 0;
            if (ea == 1) exp_pos = step4(exp_pos, d);
            chk("auto_adv", 32'(adv), ea);
            chk("auto_pos", 32'(pos), exp_pos);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        exp_pos    = 0;
        rst        = 1'b1;
        run_sw     = 1'b0;
        dir_sw     = 1'b0;
        step_key_n = 1'b1;

        // ---- Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            run_sw     = 1'($urandom_range(1));
            dir_sw     = 1'($urandom_range(1));
            step_key_n = 1'($urandom_range(1));
            cyc(1);
            chk("rst_pos", 32'(pos), 0);
            chk("rst_adv", 32'(adv), 0);
            chk("rst_running", 32'(running), 0);
        end
        rst        = 1'b0;
        run_sw     = 1'b0;
        dir_sw     = 1'b0;
        step_key_n = 1'b1;
        cyc(4);
        chk("idle_pos", 32'(pos), 0);
        chk("idle_running", 32'(running), 0);

        // ---- Auto forward: running rises 2 edges later, first step 8 after
        run_sw = 1'b1;
        cyc(1);
        chk("run_sync1", 32'(running), 0);
        cyc(1);
        chk("run_sync2", 32'(running), 1);
        run_auto(32, 8, 0);
        chk("fwd_end", 32'(pos), 0);

        // ---- Auto reverse 3,2,1,0
        dir_sw = 1'b1;
        run_auto(32, 8, 1);
        chk("rev_end", 32'(pos), 0);

        // ---- Flip direction mid-count: next tick goes forward, no extra step
        run_auto(3, 99, 1);
        dir_sw = 1'b0;
        run_auto(5, 5, 0);
        chk("flip_pos", 32'(pos), 1);

        // ---- Clean 10-cycle press while running is ignored
        step_key_n = 1'b0;
        run_auto(8, 8, 0);
        run_auto(2, 99, 0);
        step_key_n = 1'b1;
        run_auto(8, 6, 0);
        chk("run_press_pos", 32'(pos), 3);

        // ---- Reset mid-operation, then stop
        rst    = 1'b1;
        run_sw = 1'b0;
        cyc(1);
        chk("midrst_pos", 32'(pos), 0);
        chk("midrst_adv", 32'(adv), 0);
        chk("midrst_running", 32'(running), 0);
        rst = 1'b0;
        cyc(4);

        // ---- Manual step with 2-cycle bounce, then a 10-cycle hold
        for (int c = 0; c < 26; c++) begin
            if (c < 2)       step_key_n = 1'b0;
            else if (c < 4)  step_key_n = 1'b1;
            else if (c < 6)  step_key_n = 1'b0;
            else if (c < 8)  step_key_n = 1'b1;
            else if (c < 18) step_key_n = 1'b0;
            else             step_key_n = 1'b1;
            cyc(1);
            chk("man_adv", 32'(adv), (c + 1 == 15) ? 1 : 0);
            chk("man_pos", 32'(pos), (c + 1 >= 15) ? 1 : 0);
        end

        // ---- Reset mid-debounce: only the post-reset low period counts
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        step_key_n = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        chk("debrst_pos", 32'(pos), 0);
        chk("debrst_adv", 32'(adv), 0);
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            chk("debrst_adv_t", 32'(adv), (c == 7) ? 1 : 0);
            chk("debrst_pos_t", 32'(pos), (c >= 7) ? 1 : 0);
        end
        step_key_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            chk("release_adv", 32'(adv), 0);
        end
        chk("final_pos", 32'(pos), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_scroll_ctrl.md
Name: hex_scroll_ctrl

Overview:
- Upstream control stage for the four-digit HEX rotating display.
- Produces the rotation position (0..NUM_POS-1) that selects which digit pattern lands on HEX0..HEX3, plus a one-cycle advance strobe.
- Two modes: free-running at a human-visible rate when run_sw=1, or manual single-step from a debounced push-button when run_sw=0.
- Direction of rotation comes from a slide switch.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, automatic advance rate; DIV = CLK_HZ/TICK_HZ (integer, >= 2).
- NUM_POS, 4, number of rotation positions (>= 2).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a key level change (>= 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- run_sw  in  1  asynchronous slide switch; 1 = automatic, 0 = manual step
- dir_sw  in  1  asynchronous slide switch; 0 = forward (pos+1), 1 = reverse (pos-1)
- step_key_n  in  1  asynchronous push-button, active-low (pressed = 0)
- pos  out  $clog2(NUM_POS)  current rotation position
- adv  out  1  one-cycle pulse, high in the first cycle pos shows a new value
- running  out  1  synchronized copy of run_sw

Behaviour:
- Reset: synchronous on rst=1, which overrides all other inputs.
  - pos=0, adv=0, running=0, prescaler=0.
  - Key synchronizer flops=1 (released); switch synchronizer flops=0.
  - Debounce FSM in REL.
- Synchronization: each asynchronous input passes through a 2-flop synchronizer. All internal logic uses only the synchronized versions.
- Prescaler:
  - Counter width $clog2(DIV); counts 0..DIV-1 while running=1, then wraps.
  - tick = running && (count == DIV-1).
  - While running=0 the counter is held at 0, so the first tick after enabling comes DIV cycles later.
- Debounce FSM (on synchronized key k):
  - States: REL, PRESS_WAIT, HELD, REL_WAIT. Stable counter width $clog2(DEBOUNCE_CYCLES+1).
  - REL: k=0 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: k=1 -> back to REL. When DEBOUNCE_CYCLES consecutive k=0 samples are counted -> HELD, and press=1 for exactly that one cycle.
  - HELD: k=1 -> REL_WAIT, counter cleared.
  - REL_WAIT: k=0 -> back to HELD. When DEBOUNCE_CYCLES consecutive k=1 samples are counted -> REL.
  - Exactly one press per physical press. Holding the key never repeats.
- Advance condition: advance = (running && tick) || (!running && press).
  - A press while running is ignored. It is not queued.
  - A tick while stopped cannot occur.
- Position update (registered, one cycle after advance):
  - dir=0: pos = (pos == NUM_POS-1) ? 0 : pos+1.
  - dir=1: pos = (pos == 0) ? NUM_POS-1 : pos-1.
  - adv=1 in that same cycle. Otherwise pos holds and adv=0.
- Simultaneous events:
  - running and dir_sw are sampled in the cycle advance is evaluated.
  - A run_sw change and a tick or press landing on the same synchronized cycle resolve using the synchronized running value of that cycle.
- Mode switching: switching 1->0 clears the prescaler. pos is kept in both directions of the switch.
- Reset mid-operation: rst in any cycle returns every output to its reset value on the next edge. A debounce in progress is abandoned. Any pending adv is cancelled.

Decomposition:
- Shared package:
  - Debounce state enum (REL, PRESS_WAIT, HELD, REL_WAIT).
  - Board constants: CLK_HZ default 50_000_000; KEY_PRESSED = 1'b0.
  - Function for the modular increment/decrement of pos.
- One sub-module: key_debounce.
  - Contains the 2-flop synchronizer and the FSM.
  - Parameter DEBOUNCE_CYCLES; outputs the press pulse.
  - Reused for other board keys.
- Prescaler and position register live in the top.

Test Plan (CLK_HZ=8, TICK_HZ=1 so DIV=8; DEBOUNCE_CYCLES=4; NUM_POS=4):
- Reset: hold rst 3 cycles with random inputs -> pos=0, adv=0, running=0 on every cycle while rst=1.
- Auto forward: run_sw=1, dir_sw=0 -> pos steps 0,1,2,3,0 every 8 cycles, with adv high exactly one cycle per step. The first step comes 8 cycles after running rises.
- Auto reverse: from pos=0, dir_sw=1 -> pos goes 3,2,1,0. Flipping dir_sw mid-count takes effect on the next tick with no extra step.
- Manual step with bounce: run_sw=0; key toggles 0/1/0 with 2-cycle glitches, then held low 10 cycles, then released -> exactly one adv and pos 0->1. The 2-cycle glitches alone produce no adv.
- Press while running: run_sw=1, clean 10-cycle key press between ticks -> no extra adv; pos changes only on ticks.
- Reset mid-debounce: key low for 3 cycles, assert rst for 1 cycle, key stays low 6 more cycles -> exactly one press, counted from the post-reset edge (adv at 2 sync + 4 debounce + 1 cycles); pos=1 afterwards.
